// File: rtl/ifetch_if.sv
// Instruction-fetch bundle: ROM read port plus the decode-side valid/ready handshake
// and the core's redirect request.
interface ifetch_if;
  logic [63:0] HADDR;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        inst_fault;

  modport master (
    output HADDR, HWDATA, inst_valid, inst_data, inst_pc, inst_fault,
    input  HRDATA, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  HADDR, HWDATA, inst_valid, inst_data, inst_pc, inst_fault,
    output HRDATA, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: reads 8-byte ROM doublewords, extracts 32-bit words in program
// order and buffers them in a small FIFO for the decode stage; redirect flushes and restarts.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [63:0] ROM_START  = 64'h0,
  parameter int          ROM_SIZE   = 20480
) (
  input logic      HCLK,
  input logic      HRESETn,
  ifetch_if.master bus
);

  localparam int              PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [63:0]     FETCH_SPAN = 64'(ROM_SIZE) - 64'd8;

  // Offset compare: addresses below ROM_START wrap to huge offsets and fall out of range.
  function automatic logic in_rom(input logic [63:0] addr);
    return (addr - ROM_START) < FETCH_SPAN;
  endfunction

  typedef enum logic {RUN, HALT} state_t;

  state_t            state;
  logic [63:0]       fetch_pc;
  logic [63:0]       haddr;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    count;
  logic [31:0]       fifo_data  [FIFO_DEPTH];
  logic [63:0]       fifo_pc    [FIFO_DEPTH];
  logic              fifo_fault [FIFO_DEPTH];
  logic [31:0]       fetch_word;
  logic              fetch_fault;
  logic              head_vld;
  logic              pop;
  logic              push;

  assign haddr       = {fetch_pc[63:3], 3'b000};
  assign fetch_word  = fetch_pc[2] ? bus.HRDATA[63:32] : bus.HRDATA[31:0];
  assign fetch_fault = !in_rom(haddr) || (fetch_pc[1:0] != 2'b00);
  assign head_vld    = (count != '0);
  assign pop         = head_vld && bus.inst_ready;
  assign push        = (state == RUN) && ((count < DEPTH_C) || pop);

  // Control: fetch pointer, run/halt state and FIFO bookkeeping
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      state    <= RUN;
      fetch_pc <= bus.redirect_pc;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
        if (fetch_fault) state <= HALT;
        else             fetch_pc <= fetch_pc + 64'd4;
      end
      if (pop) head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W + 1)'(1);
      else if (!push && pop) count <= count - (PTR_W + 1)'(1);
    end
  end

  // Storage: entries are only meaningful below count, so no reset is needed here
  always_ff @(posedge HCLK) begin
    if (push && !bus.redirect_valid) begin
      fifo_data[tail]  <= fetch_fault ? 32'h0 : fetch_word;
      fifo_pc[tail]    <= fetch_pc;
      fifo_fault[tail] <= fetch_fault;
    end
  end

  assign bus.HADDR      = haddr;
  assign bus.HWDATA     = 64'h0;
  assign bus.inst_valid = head_vld;
  assign bus.inst_data  = head_vld ? fifo_data[head]  : 32'h0;
  assign bus.inst_pc    = head_vld ? fifo_pc[head]    : 64'h0;
  assign bus.inst_fault = head_vld ? fifo_fault[head] : 1'b0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: queue-based fetch model checked every cycle, plus
// literal expectations for the sequential, backpressure, redirect and fault scenarios.
module tb_ifetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 4;
  // Last fetchable doubleword is 0x4FF0 (ROM decode excludes the top 8 bytes).
  localparam logic [63:0] ROM_LIM  = 64'h4FF8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ifetch_if bus();

  ifetch_unit #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH),
    .ROM_START (64'h0),
    .ROM_SIZE  (20480)
  ) dut (
    .HCLK   (clk),
    .HRESETn(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // ROM contents: the 32-bit word at byte address a is (a/4)+1
  function automatic logic [31:0] word_at(input logic [63:0] a);
    return 32'((a >> 2) + 64'd1);
  endfunction

  always_comb begin
    if (bus.HADDR < ROM_LIM)
      bus.HRDATA = {word_at(bus.HADDR + 64'd4), word_at(bus.HADDR)};
    else
      bus.HRDATA = 64'hDEAD_BEEF_DEAD_BEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: list of buffered entries, next fetch address, halted flag
  typedef struct packed {
    logic [31:0] data;
    logic [63:0] pc;
    logic        fault;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_pc   = RESET_PC;
  bit          m_halt = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int   n;
    bit   popped;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
    end else if (bus.redirect_valid) begin
      q.delete();
      m_pc   = bus.redirect_pc;
      m_halt = 1'b0;
    end else begin
      n      = q.size();
      popped = (n > 0) && bus.inst_ready;
      if (popped) void'(q.pop_front());
      if (!m_halt && (n < DEPTH || popped)) begin
        e.pc = m_pc;
        if (m_pc[1:0] == 2'b00 && {m_pc[63:3], 3'b000} < ROM_LIM) begin
          e.data  = word_at(m_pc);
          e.fault = 1'b0;
          m_pc    = m_pc + 64'd4;
        end else begin
          e.data  = 32'h0;
          e.fault = 1'b1;
          m_halt  = 1'b1;
        end
        q.push_back(e);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("model_valid", 64'(bus.inst_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
          check("model_pc",    bus.inst_pc,           q[0].pc);
          check("model_data",  64'(bus.inst_data),    64'(q[0].data));
          check("model_fault", 64'(bus.inst_fault),   64'(q[0].fault));
        end
        check("model_haddr",  bus.HADDR,  {m_pc[63:3], 3'b000});
        check("model_hwdata", bus.HWDATA, 64'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic head(input string name, input logic [63:0] pc, input logic [31:0] data,
                      input logic fault);
    check({name, "_valid"}, 64'(bus.inst_valid), 64'd1);
    check({name, "_pc"},    bus.inst_pc,         pc);
    check({name, "_data"},  64'(bus.inst_data),  64'(data));
    check({name, "_fault"}, 64'(bus.inst_fault), 64'(fault));
  endtask

  task automatic redirect(input logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;

    // Reset state
    repeat (2) tick();
    check("rst_valid",  64'(bus.inst_valid), 64'd0);
    check("rst_data",   64'(bus.inst_data),  64'd0);
    check("rst_pc",     bus.inst_pc,         64'd0);
    check("rst_fault",  64'(bus.inst_fault), 64'd0);
    check("rst_haddr",  bus.HADDR,           64'h0);
    check("rst_hwdata", bus.HWDATA,          64'h0);

    // Sequential fetch
    rst_n = 1'b1;
    tick(); head("seq0", 64'h0, 32'h1, 1'b0);
    tick(); head("seq1", 64'h4, 32'h2, 1'b0);
    tick(); head("seq2", 64'h8, 32'h3, 1'b0);
    tick(); head("seq3", 64'hC, 32'h4, 1'b0);

    // Backpressure: restart at 0 with the consumer stalled for 10 cycles
    bus.inst_ready = 1'b0;
    redirect(64'h0);
    check("bp_empty", 64'(bus.inst_valid), 64'd0);
    repeat (9) tick();
    head("bp_hold", 64'h0, 32'h1, 1'b0);
    check("bp_haddr", bus.HADDR, 64'h10);
    bus.inst_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      head("bp_drain", 64'(4 * k), 32'(k + 1), 1'b0);
    end

    // Redirect with a full FIFO
    bus.inst_ready = 1'b0;
    repeat (5) tick();
    redirect(64'h104);
    check("redir_flush", 64'(bus.inst_valid), 64'd0);
    bus.inst_ready = 1'b1;
    tick(); head("redir0", 64'h104, 32'h42, 1'b0);
    tick(); head("redir1", 64'h108, 32'h43, 1'b0);

    // Top of ROM: last word of the last fetchable doubleword, then a fault
    redirect(64'h4FF4);
    tick(); head("oor_last", 64'h4FF4, 32'h13FE, 1'b0);
    tick(); head("oor_fault", 64'h4FF8, 32'h0, 1'b1);
    tick(); check("oor_stop", 64'(bus.inst_valid), 64'd0);
    repeat (3) tick();
    check("oor_halt", 64'(bus.inst_valid), 64'd0);
    check("oor_haddr", bus.HADDR, 64'h4FF8);
    redirect(64'h4FFC);
    tick(); head("oor_top", 64'h4FFC, 32'h0, 1'b1);
    tick(); check("oor_top_stop", 64'(bus.inst_valid), 64'd0);

    // Misaligned redirect
    bus.inst_ready = 1'b0;
    redirect(64'h22);
    tick(); head("mis0", 64'h22, 32'h0, 1'b1);
    repeat (3) tick();
    head("mis_hold", 64'h22, 32'h0, 1'b1);
    check("mis_haddr", bus.HADDR, 64'h20);
    bus.inst_ready = 1'b1;
    tick(); check("mis_single", 64'(bus.inst_valid), 64'd0);

    // Redirect on the same edge as a pop
    redirect(64'h40);
    tick(); head("sim_pre", 64'h40, 32'h11, 1'b0);
    redirect(64'h80);
    check("sim_flush", 64'(bus.inst_valid), 64'd0);
    tick(); head("sim_post", 64'h80, 32'h21, 1'b0);

    // Reset mid-stream
    tick(); head("mid", 64'h84, 32'h22, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.inst_valid), 64'd0);
    check("arst_data",  64'(bus.inst_data),  64'd0);
    check("arst_pc",    bus.inst_pc,         64'd0);
    check("arst_fault", 64'(bus.inst_fault), 64'd0);
    check("arst_haddr", bus.HADDR,           64'h0);
    tick();
    rst_n = 1'b1;
    tick(); head("rst_restart0", 64'h0, 32'h1, 1'b0);
    tick(); head("rst_restart1", 64'h4, 32'h2, 1'b0);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
